// File: rtl/vga_sync_controller.sv
// vga_sync_controller: VGA raster timing with pixel request and latency-matched OE/hsync/vsync.
// Define VGA_FRAME_CNT_EN to add the 8-bit frame_cnt output.
module vga_sync_controller #(
  parameter int CLK_DIV   = 4,
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int FETCH_LAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       pix_tick,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       pix_req,
  output logic       OE,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [7:0] frame_cnt
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0]       X_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]       Y_LAST   = 10'(V_TOTAL - 1);
  localparam logic [10:0]      H_ACT_L  = 11'(H_ACTIVE);
  localparam logic [10:0]      HS_BEG_L = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0]      HS_END_L = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0]      V_ACT_L  = 11'(V_ACTIVE);
  localparam logic [10:0]      VS_BEG_L = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0]      VS_END_L = 11'(V_ACTIVE + V_FP + V_SYNC);

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_total_check
    $error("vga_sync_controller: H_TOTAL and V_TOTAL must not exceed 1024");
  end
  if (CLK_DIV < 1 || FETCH_LAT < 0 || FETCH_LAT > 7) begin : g_param_check
    $error("vga_sync_controller: CLK_DIV must be >= 1 and FETCH_LAT within 0..7");
  end

  logic [DIV_W-1:0] div_q, div_d;
  logic             tick_q, tick_d;
  logic [9:0]       x_q, x_d, y_q, y_d;
  logic             run_q, run_d;
  logic             req_q, req_d, hs_q, hs_d, vs_q, vs_d;
  logic             fs_q, fs_d;
`ifdef VGA_FRAME_CNT_EN
  logic [7:0]       cnt_q, cnt_d;
`endif

  // run_q marks that the first tick after enable has landed the raster on (0,0)
  always_comb begin
    div_d  = div_q;
    tick_d = 1'b0;
    x_d    = x_q;
    y_d    = y_q;
    run_d  = run_q;
    req_d  = req_q;
    hs_d   = hs_q;
    vs_d   = vs_q;
    fs_d   = 1'b0;
    if (!en) begin
      div_d = '0;
      x_d   = 10'd0;
      y_d   = 10'd0;
      run_d = 1'b0;
      req_d = 1'b0;
      hs_d  = 1'b1;
      vs_d  = 1'b1;
    end else begin
      tick_d = (div_q == DIV_LAST);
      div_d  = tick_d ? '0 : div_q + DIV_W'(1);
      if (tick_d) begin
        if (!run_q) begin
          x_d   = 10'd0;
          y_d   = 10'd0;
          run_d = 1'b1;
        end else if (x_q == X_LAST) begin
          x_d = 10'd0;
          if (y_q == Y_LAST) begin
            y_d  = 10'd0;
            fs_d = 1'b1;
          end else begin
            y_d = y_q + 10'd1;
          end
        end else begin
          x_d = x_q + 10'd1;
        end
        req_d = ({1'b0, x_d} < H_ACT_L) && ({1'b0, y_d} < V_ACT_L);
        hs_d  = !(({1'b0, x_d} >= HS_BEG_L) && ({1'b0, x_d} < HS_END_L));
        vs_d  = !(({1'b0, y_d} >= VS_BEG_L) && ({1'b0, y_d} < VS_END_L));
      end else begin
        run_d = run_q;
      end
    end
  end

`ifdef VGA_FRAME_CNT_EN
  always_comb begin
    cnt_d = cnt_q;
    if (!en) begin
      cnt_d = 8'd0;
    end else if (fs_d) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= 8'd0;
    else        cnt_q <= cnt_d;
  end

  assign frame_cnt = cnt_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      tick_q <= 1'b0;
      x_q    <= 10'd0;
      y_q    <= 10'd0;
      run_q  <= 1'b0;
      req_q  <= 1'b0;
      hs_q   <= 1'b1;
      vs_q   <= 1'b1;
      fs_q   <= 1'b0;
    end else begin
      div_q  <= div_d;
      tick_q <= tick_d;
      x_q    <= x_d;
      y_q    <= y_d;
      run_q  <= run_d;
      req_q  <= req_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      fs_q   <= fs_d;
    end
  end

  // {req, hsync, vsync} delayed so OE and syncs line up with fetched RGB data
  if (FETCH_LAT == 0) begin : g_no_delay
    assign OE    = req_q;
    assign hsync = hs_q;
    assign vsync = vs_q;
  end else begin : g_delay
    logic [2:0] dly_q [FETCH_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < FETCH_LAT; i++) dly_q[i] <= 3'b011;
      end else if (!en) begin
        for (int i = 0; i < FETCH_LAT; i++) dly_q[i] <= 3'b011;
      end else if (tick_d) begin
        dly_q[0] <= {req_q, hs_q, vs_q};
        for (int i = 1; i < FETCH_LAT; i++) dly_q[i] <= dly_q[i-1];
      end else begin
        dly_q[0] <= dly_q[0];
      end
    end

    assign OE    = dly_q[FETCH_LAT-1][2];
    assign hsync = dly_q[FETCH_LAT-1][1];
    assign vsync = dly_q[FETCH_LAT-1][0];
  end

  assign pix_tick    = tick_q;
  assign pix_x       = x_q;
  assign pix_y       = y_q;
  assign pix_req     = req_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_sync_controller.sv
// Bench for vga_sync_controller: two shrunk-timing instances checked every cycle against an
// arithmetic model derived from the number of enabled clocks since the raster restarted.
module tb_vga_sync_controller;

  localparam int A_DIV = 1, A_HA = 8,  A_HF = 2, A_HS = 2, A_HB = 2;
  localparam int A_VA  = 4, A_VF = 1,  A_VS = 1, A_VB = 1, A_LAT = 1;
  localparam int B_DIV = 4, B_HA = 10, B_HF = 3, B_HS = 4, B_HB = 3;
  localparam int B_VA  = 5, B_VF = 2,  B_VS = 2, B_VB = 1, B_LAT = 3;

  typedef struct packed {
    logic       tick;
    logic [9:0] x;
    logic [9:0] y;
    logic       req;
    logic       oe;
    logic       hs;
    logic       vs;
    logic       fs;
    logic [7:0] cnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       a_tick, a_req, a_oe, a_hs, a_vs, a_fs;
  logic       b_tick, b_req, b_oe, b_hs, b_vs, b_fs;
  logic [9:0] a_x, a_y, b_x, b_y;
`ifdef VGA_FRAME_CNT_EN
  logic [7:0] a_cnt, b_cnt;
`endif

  int k;
  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  vga_sync_controller #(
    .CLK_DIV(A_DIV), .H_ACTIVE(A_HA), .H_FP(A_HF), .H_SYNC(A_HS), .H_BP(A_HB),
    .V_ACTIVE(A_VA), .V_FP(A_VF), .V_SYNC(A_VS), .V_BP(A_VB), .FETCH_LAT(A_LAT)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .pix_tick(a_tick), .pix_x(a_x), .pix_y(a_y),
    .pix_req(a_req), .OE(a_oe), .hsync(a_hs), .vsync(a_vs), .frame_start(a_fs)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt(a_cnt)
`endif
  );

  vga_sync_controller #(
    .CLK_DIV(B_DIV), .H_ACTIVE(B_HA), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
    .V_ACTIVE(B_VA), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB), .FETCH_LAT(B_LAT)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .pix_tick(b_tick), .pix_x(b_x), .pix_y(b_y),
    .pix_req(b_req), .OE(b_oe), .hsync(b_hs), .vsync(b_vs), .frame_start(b_fs)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt(b_cnt)
`endif
  );

  // enabled clock edges since reset or the last en-low clock
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)  k <= 0;
    else if (en) k <= k + 1;
    else         k <= 0;
  end

  function automatic logic [2:0] raw_at(input int n, input int ha, input int hf, input int hsw,
                                        input int ht, input int va, input int vf, input int vsw,
                                        input int vt);
    int p, x, y;
    if (n < 1) return 3'b011;
    p = n - 1;
    x = p % ht;
    y = (p / ht) % vt;
    return {(x < ha) && (y < va),
            !((x >= ha + hf) && (x < ha + hf + hsw)),
            !((y >= va + vf) && (y < va + vf + vsw))};
  endfunction

  function automatic exp_t model(input int kk, input bit sel);
    int div, ha, hf, hsw, hb, va, vf, vsw, vb, lat, ht, vt, n, p;
    exp_t e;
    logic [2:0] cur, dl;
    if (sel) begin
      div = B_DIV; ha = B_HA; hf = B_HF; hsw = B_HS; hb = B_HB;
      va = B_VA; vf = B_VF; vsw = B_VS; vb = B_VB; lat = B_LAT;
    end else begin
      div = A_DIV; ha = A_HA; hf = A_HF; hsw = A_HS; hb = A_HB;
      va = A_VA; vf = A_VF; vsw = A_VS; vb = A_VB; lat = A_LAT;
    end
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    n  = kk / div;
    e.tick = (kk > 0) && (kk % div == 0);
    cur = raw_at(n, ha, hf, hsw, ht, va, vf, vsw, vt);
    dl  = raw_at(n - lat, ha, hf, hsw, ht, va, vf, vsw, vt);
    if (n >= 1) begin
      p     = n - 1;
      e.x   = 10'(p % ht);
      e.y   = 10'((p / ht) % vt);
      e.fs  = e.tick && (p > 0) && (p % (ht * vt) == 0);
      e.cnt = 8'((p / (ht * vt)) % 256);
    end else begin
      e.x   = 10'd0;
      e.y   = 10'd0;
      e.fs  = 1'b0;
      e.cnt = 8'd0;
    end
    e.req = cur[2];
    e.oe  = dl[2];
    e.hs  = dl[1];
    e.vs  = dl[0];
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t, k=%0d)", tag, obs, exp, $time, k);
  endtask

  task automatic compare_all();
    exp_t ea, eb;
    ea = model(k, 1'b0);
    eb = model(k, 1'b1);
    check("a_tick", 32'(a_tick), 32'(ea.tick));
    check("a_x",    32'(a_x),    32'(ea.x));
    check("a_y",    32'(a_y),    32'(ea.y));
    check("a_req",  32'(a_req),  32'(ea.req));
    check("a_oe",   32'(a_oe),   32'(ea.oe));
    check("a_hs",   32'(a_hs),   32'(ea.hs));
    check("a_vs",   32'(a_vs),   32'(ea.vs));
    check("a_fs",   32'(a_fs),   32'(ea.fs));
    check("b_tick", 32'(b_tick), 32'(eb.tick));
    check("b_x",    32'(b_x),    32'(eb.x));
    check("b_y",    32'(b_y),    32'(eb.y));
    check("b_req",  32'(b_req),  32'(eb.req));
    check("b_oe",   32'(b_oe),   32'(eb.oe));
    check("b_hs",   32'(b_hs),   32'(eb.hs));
    check("b_vs",   32'(b_vs),   32'(eb.vs));
    check("b_fs",   32'(b_fs),   32'(eb.fs));
`ifdef VGA_FRAME_CNT_EN
    check("a_cnt",  32'(a_cnt),  32'(ea.cnt));
    check("b_cnt",  32'(b_cnt),  32'(eb.cnt));
`endif
  endtask

  task automatic run(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      compare_all();
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int last_fs;
    int found;
    int mode;
    int len;

    rst_n = 1'b0;
    en    = 1'b0;
    repeat (3) @(negedge clk);
    compare_all();
    check("rst_a_hsync", 32'(a_hs), 32'd1);
    check("rst_a_oe",    32'(a_oe), 32'd0);
    check("rst_b_x",     32'(b_x),  32'd0);

    rst_n = 1'b1;
    en    = 1'b1;
    last_fs = -1;
    for (int c = 0; c < 1700; c++) begin
      @(negedge clk);
      compare_all();
      if (a_fs) begin
        if (last_fs >= 0) check("a_frame_period", 32'(c - last_fs), 32'd98);
        last_fs = c;
      end
    end
    check("a_saw_frames", 32'(last_fs >= 0), 32'd1);

    found = 0;
    for (int c = 0; c < 200 && found == 0; c++) begin
      @(negedge clk);
      compare_all();
      if (a_x == 10'd5) found = 1;
    end
    check("t5_reach_x5", 32'(found), 32'd1);
    en = 1'b0;
    @(negedge clk);
    compare_all();
    check("t5_x",  32'(a_x),  32'd0);
    check("t5_y",  32'(a_y),  32'd0);
    check("t5_oe", 32'(a_oe), 32'd0);
    check("t5_hs", 32'(a_hs), 32'd1);
    check("t5_vs", 32'(a_vs), 32'd1);
    run(3);
    en = 1'b1;
    found = 0;
    for (int c = 1; c <= 300 && found == 0; c++) begin
      @(negedge clk);
      compare_all();
      if (a_fs) begin
        check("t5_first_fs_clock", 32'(c), 32'd99);
        found = 1;
      end
    end
    check("t5_fs_seen", 32'(found), 32'd1);

    found = 0;
    for (int c = 0; c < 200 && found == 0; c++) begin
      @(negedge clk);
      compare_all();
      if (a_hs == 1'b0) found = 1;
    end
    check("t6_reach_hsync", 32'(found), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    compare_all();
    check("t6_hsync", 32'(a_hs), 32'd1);
    check("t6_oe",    32'(a_oe), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    compare_all();
    check("t6_restart_x", 32'(a_x), 32'd0);
    check("t6_restart_y", 32'(a_y), 32'd0);
    run(40);

    for (int s = 0; s < 60; s++) begin
      mode = int'($urandom_range(0, 9));
      if (mode < 7) begin
        en  = 1'b1;
        len = int'($urandom_range(1, 500));
      end else if (mode < 9) begin
        en  = 1'b0;
        len = int'($urandom_range(1, 12));
      end else begin
        #($urandom_range(1, 3));
        rst_n = 1'b0;
        #1;
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'($urandom_range(0, 1));
        len   = int'($urandom_range(1, 50));
      end
      run(len);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
